// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;

    // Expected parity bit for a zero-extended word; 0 when parity is off.
    function automatic logic par_calc(input logic [15:0] word, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return ^word;
            PAR_ODD:  return ~^word;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: two-flop synchroniser, falling-edge detect and a
// three-sample majority vote around the middle of each bit period.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVS = 16,
    localparam int CW = $clog2(OVS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          rx_i,
    input  logic [CW-1:0] cnt_i,
    output logic          start_edge_o,
    output logic          bit_val_o,
    output logic          bit_strobe_o
);

    localparam logic [CW-1:0] C_MM1 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] C_M   = CW'(OVS / 2);
    localparam logic [CW-1:0] C_MP1 = CW'(OVS / 2 + 1);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       samp_mm1_q;
    logic       samp_m_q;
    logic       line;

    assign line = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            samp_mm1_q <= 1'b1;
            samp_m_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= line;
            if (tick_i && cnt_i == C_MM1) samp_mm1_q <= line;
            if (tick_i && cnt_i == C_M)   samp_m_q   <= line;
        end
    end

    // The third sample is the live line value on the deciding tick.
    assign start_edge_o = prev_q & ~line;
    assign bit_strobe_o = tick_i && (cnt_i == C_MP1);
    assign bit_val_o    = (samp_mm1_q & samp_m_q) | (samp_mm1_q & line) | (samp_m_q & line);

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: frame FSM, oversampling counter, shift register
// and a one-entry valid/ready holding register with error flags.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tick_i,
    input  logic              rx_en_i,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_MAX   = CW'(OVS - 1);
    localparam logic [1:0]    PAR_MODE  = 2'(PARITY);
    localparam logic [4:0]    LAST_DATA = 5'(DATA_W - 1);
    localparam logic [4:0]    LAST_STOP = 5'(STOP_BITS - 1);

    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4:0]        bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              commit;

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              perr_o_q, perr_o_d;
    logic              ferr_o_q, ferr_o_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic start_edge;
    logic bit_val;
    logic bit_strobe;

    uart_rx_sampler #(.OVS(OVS)) u_sampler (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tick_i      (tick_i),
        .rx_i        (rx_i),
        .cnt_i       (cnt_q),
        .start_edge_o(start_edge),
        .bit_val_o   (bit_val),
        .bit_strobe_o(bit_strobe)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;
        if (tick_i) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_edge && rx_en_i) begin
                    state_d = ST_START;
                    bcnt_d  = '0;
                    shift_d = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    if (MSB_FIRST != 0) shift_d = {shift_q[DATA_W-2:0], bit_val};
                    else                shift_d = {bit_val, shift_q[DATA_W-1:1]};
                    if (bcnt_q == LAST_DATA) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    if (bit_val != par_calc(16'(shift_q), PAR_MODE)) perr_d = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    if (!bit_val) ferr_d = 1'b1;
                    // Commit on the last stop decision, not at the end of the bit.
                    if (bcnt_q == LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !rx_en_i) begin
            state_d = ST_IDLE;
            commit  = 1'b0;
        end
    end

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        ovr_d    = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        if (commit) begin
            if (!valid_q || ready_i) begin
                data_d   = shift_d;
                perr_o_d = perr_d;
                ferr_o_d = ferr_d;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_o_q;
    assign frame_err_o  = ferr_o_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = busy_q;

endmodule
